sram_controller: RTL and testbench
==================================

# sram_controller

MEM-stage memory controller on the response side of the EXE-stage memory request. It accepts the ALU result as a byte address, the Rm value as store data and the registered read/write enables, then runs a 32-bit load or store as two 16-bit external SRAM accesses. While busy it holds `ready` low so the pipeline freezes. It returns the loaded word on `read_data` for writeback.

## Interface
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, default 2: idle settle cycles after the second half-access (0–15).
- `clk` in 1: pipeline clock.
- `rst` in 1: reset, synchronous, active-high. One clock; every flop resets on `rst` at the rising edge of `clk`.
- `rd_en` in 1: load request, level, held by the pipeline while `ready`=0.
- `wr_en` in 1: store request, level, held while `ready`=0.
- `address` in 32: byte address (ALU result).
- `write_data` in 32: store data (Rm value).
- `read_data` out 32: loaded word, registered.
- `ready` out 1: 1 = no transfer pending. Pipeline freeze = ~`ready`.
- `sram_addr` out 18: SRAM halfword address, registered.
- `sram_dq_out` out 16: write data to the pad tristate.
- `sram_dq_oe` out 1: pad output enable.
- `sram_dq_in` in 16: read data from the pad.
- `sram_we_n` out 1: SRAM write strobe, active low.
- `sram_oe_n` out 1: SRAM output enable, active low.

## Operation
- Word index `w` = (`address` − `BASE_ADDR`)[18:2], 17 bits; the subtraction wraps modulo 2^32.
- The low half is at `{w,0}` and carries bits 15:0. The high half is at `{w,1}` and carries bits 31:16.
- The low 2 address bits are ignored.
- FSM states:
  - IDLE: if `wr_en` or `rd_en` → LOW; else stay. `wr_en` has priority when both are set; that transfer is a store only.
  - LOW: access the low half → HIGH.
  - HIGH: access the high half → WAIT if `WAIT_CYCLES`>0, else DONE.
  - WAIT: count down `WAIT_CYCLES` cycles → DONE.
  - DONE: one cycle → IDLE.
- Store behaviour:
  - In LOW and HIGH: `sram_we_n`=0, `sram_dq_oe`=1, `sram_dq_out` = the matching half of `write_data`.
  - In every other state: `sram_we_n`=1, `sram_dq_oe`=0.
- Load behaviour:
  - In LOW and HIGH: `sram_oe_n`=0.
  - `sram_dq_in` is captured into `read_data[15:0]` on the edge leaving LOW, and into `read_data[31:16]` on the edge leaving HIGH.
  - `read_data` holds its value until the next load completes. Stores do not modify it.
- `ready` is combinational: 1 when (IDLE and no request) or DONE; 0 otherwise. A request is therefore frozen from its first cycle.
- The request inputs are sampled only in IDLE. Changes to them during a transfer are ignored.
- Reset mid-transfer:
  - FSM → IDLE and the wait count clears.
  - `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0.
  - `sram_addr`=0, `read_data`=0.
  - The partial store is not completed.

## Timing
- Reset values:
  - `read_data`=0, `sram_addr`=0, `sram_dq_out`=0.
  - `sram_dq_oe`=0, `sram_we_n`=1, `sram_oe_n`=1.
  - `ready`=1 while no request is present.
- A request first seen in IDLE at cycle 0 gives `ready`=0 for cycles 0 .. 2+`WAIT_CYCLES`, and `ready`=1 at cycle 3+`WAIT_CYCLES` (DONE). With the default that is cycle 5.
- A load's `read_data` is valid in the DONE cycle and after it.
- The pipeline advances on the DONE edge. A back-to-back request is seen in the following IDLE cycle, giving one non-frozen cycle between transfers.
- `sram_addr` is registered. It is updated on entry to LOW (low-half address) and on entry to HIGH (high-half address).

## Configuration
- `SRAM_CTRL_ADDR_CHECK_EN` defined:
  - A request with `address` < `BASE_ADDR` or `address` ≥ `BASE_ADDR`+2^19 goes IDLE → DONE directly.
  - No SRAM strobe is asserted.
  - A load sets `read_data`=0.
  - `ready` returns after 1 frozen cycle.
- Undefined: no check; the address wraps per the `w` formula.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, LOW, HIGH, WAIT, DONE).
  - SRAM width constants (address 18, data 16).
  - Default `BASE_ADDR`.
- One sub-module, `sram_wait_counter`:
  - 4-bit down-counter with load and done outputs.
  - Cleared by `rst`.

## Test plan
- Store `address`=1024, `write_data`=0xDEADBEEF: `sram_addr`=0 with dq 0xBEEF and `sram_we_n`=0, then `sram_addr`=1 with dq 0xDEAD. `ready`=0 for 5 cycles, then 1.
- Load back from 1024 with the SRAM model: `read_data`=0xDEADBEEF in DONE. Store 0x12345678 at 1028 → `sram_addr` 2 then 3.
- `rd_en` and `wr_en` both high at 1032 with `write_data`=0x0000CAFE: the store executes, and `read_data` keeps its previous value.
- `rst` asserted during HIGH of a store: next cycle `sram_we_n`=1, `sram_dq_oe`=0, `ready`=1, `read_data`=0.
- Back-to-back loads from 1024 and 1028: each freezes 5 cycles, with exactly one `ready`=1 cycle (DONE) between them.
- With `SRAM_CTRL_ADDR_CHECK_EN`, load from 512: no strobes, `read_data`=0, `ready`=0 for 1 cycle. Without the macro, the same load accesses `sram_addr` {0x1FF80,0} and {0x1FF80,1}.

Source files
------------

// File: rtl/sram_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller_pkg
//  Description : Shared definitions for the MEM-stage SRAM controller:
//                FSM state encoding, external SRAM widths, wait-counter
//                width and the default base byte address.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_controller_pkg;

    // External SRAM geometry: 256K x 16
    localparam int SRAM_AW    = 18;
    localparam int SRAM_DW    = 16;

    // Width of the post-access settle counter (WAIT_CYCLES 0..15)
    localparam int WAIT_CNT_W = 4;

    // Byte address that maps to SRAM word 0
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage : sram_controller_pkg
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_wait_counter
//  Description : 4-bit down-counter used to time the idle settle period
//                after the second half-access. load_i has priority over
//                en_i; done_o is high while the count is zero.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                load_i        - load load_val_i into the counter
//                load_val_i    - value to load
//                en_i          - decrement by one (saturates at zero)
//                count_o       - current count
//                done_o        - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter
    import sram_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [WAIT_CNT_W-1:0] load_val_i,
    input  logic                  en_i,
    output logic [WAIT_CNT_W-1:0] count_o,
    output logic                  done_o
);

    logic [WAIT_CNT_W-1:0] count_q;
    logic [WAIT_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == '0);

endmodule : sram_wait_counter
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller
//  Description : MEM-stage controller that performs a 32-bit load or store
//                as two 16-bit accesses to an external SRAM (low half at
//                {w,0}, high half at {w,1}, w = (address-BASE_ADDR)[18:2]).
//                ready drops for the whole transfer so the pipeline freezes.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                rd_en, wr_en        - load / store request (wr_en wins)
//                address, write_data - byte address and store data
//                read_data, ready    - loaded word, not-busy indication
//                sram_addr           - SRAM halfword address (registered)
//                sram_dq_out/_oe/_in - pad data out, output enable, data in
//                sram_we_n, sram_oe_n- SRAM strobes, active low
//  Options     : SRAM_CTRL_ADDR_CHECK_EN - out-of-window requests go
//                straight to DONE with no SRAM access; loads return 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam bit HAS_WAIT = (WAIT_CYCLES != 0);
    // Counter is loaded with N-1 on leaving HIGH so WAIT lasts exactly N cycles
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        HAS_WAIT ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e              state_q,     state_d;
    logic                is_store_q,  is_store_d;
    logic [SRAM_AW-2:0]  word_q,      word_d;
    logic [31:0]         wdata_q,     wdata_d;
    logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
    logic [31:0]         read_data_q, read_data_d;

    logic                w_req;
    logic [31:0]         w_offset;
    logic [SRAM_AW-2:0]  w_word;
    logic                w_oob;
    logic                w_unused_bits;
    logic                w_cnt_load;
    logic                w_cnt_en;
    logic                w_cnt_done;
    logic [WAIT_CNT_W-1:0] w_cnt_value;
    logic                w_access;

    assign w_req    = rd_en | wr_en;
    assign w_offset = address - BASE_ADDR;
    assign w_word   = w_offset[18:2];
    // Byte-lane bits and bits above the 512 KiB window do not select a word
    assign w_unused_bits = ^{w_offset[31:19], w_offset[1:0], w_cnt_value};

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    // 33-bit compare so the window end cannot overflow for a high BASE_ADDR
    assign w_oob = (address < BASE_ADDR) ||
                   ({1'b0, address} >= ({1'b0, BASE_ADDR} + 33'h0_0008_0000));
`else
    assign w_oob = 1'b0;
`endif

    sram_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_cnt_load),
        .load_val_i (WAIT_LOAD),
        .en_i       (w_cnt_en),
        .count_o    (w_cnt_value),
        .done_o     (w_cnt_done)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        sram_addr_d = sram_addr_q;
        read_data_d = read_data_q;
        w_cnt_load  = 1'b0;
        w_cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    // Request is latched here; later input changes are ignored
                    is_store_d = wr_en;
                    word_d     = w_word;
                    wdata_d    = write_data;
                    if (w_oob) begin
                        state_d = ST_DONE;
                        if (!wr_en) begin
                            read_data_d = '0;
                        end
                    end else begin
                        state_d     = ST_LOW;
                        sram_addr_d = {w_word, 1'b0};
                    end
                end
            end
            ST_LOW: begin
                state_d     = ST_HIGH;
                sram_addr_d = {word_q, 1'b1};
                if (!is_store_q) begin
                    read_data_d[15:0] = sram_dq_in;
                end
            end
            ST_HIGH: begin
                if (!is_store_q) begin
                    read_data_d[31:16] = sram_dq_in;
                end
                if (HAS_WAIT) begin
                    state_d    = ST_WAIT;
                    w_cnt_load = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (w_cnt_done) begin
                    state_d = ST_DONE;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            is_store_q  <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            sram_addr_q <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            sram_addr_q <= sram_addr_d;
            read_data_q <= read_data_d;
        end
    end

    // ------------------------------------------------------------------
    // SRAM strobes and handshake, decoded from the current state
    // ------------------------------------------------------------------
    assign w_access = (state_q == ST_LOW) || (state_q == ST_HIGH);

    always_comb begin
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        if (w_access) begin
            if (is_store_q) begin
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state_q == ST_LOW) ? wdata_q[15:0] : wdata_q[31:16];
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

    // Combinational so a new request freezes the pipeline in its first cycle
    assign ready = ((state_q == ST_IDLE) && !w_req) || (state_q == ST_DONE);

    assign sram_addr = sram_addr_q;
    assign read_data = read_data_q;

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_controller
//  Description : Self-checking bench for sram_controller. A driver issues
//                directed and random transfers and pushes the expected
//                outcome of each into a queue; a monitor watches the SRAM
//                pins while ready is low and compares each completed
//                transfer against the front of the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    localparam logic [31:0] BASE = 32'd1024;
    localparam int          WAITC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n, sram_oe_n;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // External SRAM pad model (halfword storage, reads 0 when unwritten)
    // ------------------------------------------------------------------
    logic [15:0] sram_mem [int unsigned];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_out;
    end

    // Address and strobes settle after the rising edge; present data by the falling edge
    initial sram_dq_in = 16'h5A5A;
    always @(negedge clk) begin
        if (!sram_oe_n)
            sram_dq_in = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : 16'h0000;
        else
            sram_dq_in = 16'h5A5A;
    end

    // ------------------------------------------------------------------
    // Reference model: word-addressed memory plus last loaded value
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_store;
        bit          oob;
        int unsigned lo;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          frozen;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_rd = 32'h0;

    function automatic exp_t model(input bit rd, input bit wr, input logic [31:0] a,
                                   input logic [31:0] d);
        exp_t        e;
        logic [31:0] off;
        int unsigned w;
        off = a - BASE;
        w   = (off / 4) % 131072;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        e.oob = (a < BASE) || (64'(a) >= 64'(BASE) + 64'd524288);
`else
        e.oob = 1'b0;
`endif
        e.is_store = wr;
        e.lo       = w * 2;
        e.wdata    = d;
        e.frozen   = e.oob ? 1 : 3 + WAITC;
        if (wr) begin
            if (!e.oob) ref_mem[w] = d;
            e.rd = last_rd;
        end else begin
            if (e.oob)                 e.rd = 32'h0;
            else if (ref_mem.exists(w)) e.rd = ref_mem[w];
            else                        e.rd = 32'h0;
            last_rd = e.rd;
        end
        if (!rd && !wr) e.rd = last_rd;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: collect SRAM activity while frozen, check on completion
    // ------------------------------------------------------------------
    typedef struct {
        bit          wr;
        bit          oe;
        logic [17:0] addr;
        logic [15:0] dq;
    } obs_t;

    obs_t obs_q[$];
    int   run = 0;

    always @(negedge clk) begin
        if (rst) begin
            run = 0;
            obs_q.delete();
        end else if (!ready) begin
            run++;
            if (!sram_we_n) obs_q.push_back('{1'b1, sram_dq_oe, sram_addr, sram_dq_out});
            if (!sram_oe_n) obs_q.push_back('{1'b0, sram_dq_oe, sram_addr, 16'h0});
        end else if (run > 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_completion", 32'(run), 32'h0);
            end else begin
                exp_t e;
                int   nexp;
                e    = exp_q.pop_front();
                nexp = e.oob ? 0 : 2;
                chk("frozen_cycles", 32'(run), 32'(e.frozen));
                chk("strobe_count", 32'(obs_q.size()), 32'(nexp));
                if (obs_q.size() == nexp) begin
                    for (int i = 0; i < nexp; i++) begin
                        chk("sram_addr", 32'(obs_q[i].addr), 32'(e.lo + i));
                        chk("strobe_is_write", 32'(obs_q[i].wr), 32'(e.is_store));
                        chk("dq_oe", 32'(obs_q[i].oe), 32'(e.is_store));
                        if (e.is_store)
                            chk("dq_out", 32'(obs_q[i].dq),
                                (i == 0) ? 32'(e.wdata[15:0]) : 32'(e.wdata[31:16]));
                    end
                end
                chk("read_data", read_data, e.rd);
            end
            run = 0;
            obs_q.delete();
        end
    end

    // ------------------------------------------------------------------
    // Driver: called just after a rising edge; returns just after the
    // rising edge that leaves DONE, with request inputs deasserted.
    // ------------------------------------------------------------------
    task automatic xfer(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit done;
        exp_q.push_back(model(rd, wr, a, d));
        rd_en      = rd;
        wr_en      = wr;
        address    = a;
        write_data = d;
        done       = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
        end
        if (!done) chk("transfer_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        chk("rst_we_n", 32'(sram_we_n), 32'h1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'h1);
        chk("rst_ready", 32'(ready), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // Directed transfers
        xfer(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        idle(1);
        xfer(1'b1, 1'b0, 32'd1024, 32'h0);
        xfer(1'b0, 1'b1, 32'd1028, 32'h12345678);
        idle(2);
        xfer(1'b1, 1'b1, 32'd1032, 32'h0000CAFE);
        idle(2);

        // Reset during the HIGH half of a store
        address    = 32'd5120;
        write_data = 32'hFEEDF00D;
        wr_en      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("high_we_n", 32'(sram_we_n), 32'h0);
        chk("high_sram_addr", 32'(sram_addr), 32'd2049);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_we_n", 32'(sram_we_n), 32'h1);
        chk("midrst_dq_oe", 32'(sram_dq_oe), 32'h0);
        chk("midrst_ready", 32'(ready), 32'h1);
        chk("midrst_read_data", read_data, 32'h0);
        chk("midrst_sram_addr", 32'(sram_addr), 32'h0);
        last_rd = 32'h0;
        idle(1);

        // Back-to-back loads
        xfer(1'b1, 1'b0, 32'd1024, 32'h0);
        xfer(1'b1, 1'b0, 32'd1028, 32'h0);
        idle(1);

        // Below the base address: wraps, or is rejected with the range check
        xfer(1'b0, 1'b1, 32'd512, 32'hA5A51234);
        idle(1);
        xfer(1'b1, 1'b0, 32'd1024, 32'h0);
        xfer(1'b1, 1'b0, 32'd512, 32'h0);
        idle(1);

        // Random traffic over a 16-word window, random byte offsets and gaps
        for (int n = 0; n < 40; n++) begin
            int unsigned op;
            op = $urandom_range(0, 2);
            xfer(op != 1, op != 0, BASE + 32'($urandom_range(0, 63)), $urandom);
            idle($urandom_range(0, 2));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_sram_controller
`default_nettype wire
